// File: rtl/aes_ahb_pkg.sv
// Shared types and constants for the AES key/data AHB-Lite initiator.
// Optional feature macro used by this slice: AHB_MASTER_TIMEOUT_EN.
package aes_ahb_pkg;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_KEY_A = 4'd1,
        ST_KEY_D = 4'd2,
        ST_DAT_A = 4'd3,
        ST_DAT_D = 4'd4,
        ST_RD_A  = 4'd5,
        ST_RD_D  = 4'd6,
        ST_DONE  = 4'd7,
        ST_ERR   = 4'd8
    } state_e;

    localparam logic [1:0]  HTRANS_IDLE   = 2'b00;
    localparam logic [1:0]  HTRANS_NONSEQ = 2'b10;
    localparam logic [15:0] KEY_ADDR      = 16'h0000;
    localparam logic [15:0] DATA_ADDR     = 16'h0020;

    // True while a transfer is waiting in its data phase.
    function automatic logic is_data_phase(input state_e st);
        logic r;
        case (st)
            ST_KEY_D, ST_DAT_D, ST_RD_D: r = 1'b1;
            default:                     r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/aes_ahb_master_timer.sv
// Data-phase wait counter: counts HREADY-low cycles, flags the last allowed one.
// Only instantiated when AHB_MASTER_TIMEOUT_EN is defined.
module ahb_wait_timer #(
    parameter int LIMIT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic wait_en,
    output logic expired
);
    localparam int            CW   = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: restart on phase entry, saturate on the last wait cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = {CW{1'b0}};
        end else if (wait_en && (cnt_q != LAST)) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= {CW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Combinational so the master's next-state logic leaves the phase in the same cycle.
    assign expired = wait_en && (cnt_q == LAST);

endmodule

// File: rtl/aes_ahb_master.sv
// AHB-Lite initiator: writes key to 0x0000, data to 0x0020, reads 0x0020 back.
// Define AHB_MASTER_TIMEOUT_EN to abort data phases stuck low on HREADY.
// All outputs are flops loaded from the next-state decode, so they line up with the state.
module aes_ahb_master
    import aes_ahb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    input  logic [127:0] data_in,
    output logic         busy,
    output logic         done,
    output logic         error,
    output logic [127:0] result,
    output logic [15:0]  HADDR,
    output logic [1:0]   HTRANS,
    output logic         HWRITE,
    output logic [127:0] HWDATA,
    input  logic [127:0] HRDATA,
    input  logic         HREADY,
    input  logic         HRESP
);
    state_e         state_q, state_d;
    logic [127:0]   key_q, key_d;
    logic [127:0]   data_q, data_d;
    logic [127:0]   result_q, result_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           error_q, error_d;
    logic [15:0]    haddr_q, haddr_d;
    logic [1:0]     htrans_q, htrans_d;
    logic           hwrite_q, hwrite_d;
    logic [127:0]   hwdata_q, hwdata_d;
    logic           timeout_s;

`ifdef AHB_MASTER_TIMEOUT_EN
    logic data_phase_s;
    assign data_phase_s = is_data_phase(state_q);

    ahb_wait_timer #(.LIMIT(TIMEOUT_CYCLES)) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (!data_phase_s),
        .wait_en (data_phase_s && !HREADY),
        .expired (timeout_s)
    );
`else
    logic [31:0] unused_timeout_s;
    assign unused_timeout_s = 32'(TIMEOUT_CYCLES);
    assign timeout_s        = 1'b0;
`endif

    // Next state, operand capture and read-data capture; HRESP outranks HREADY.
    always_comb begin
        state_d  = state_q;
        key_d    = key_q;
        data_d   = data_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    key_d   = key_in;
                    data_d  = data_in;
                    state_d = ST_KEY_A;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_KEY_A: state_d = ST_KEY_D;
            ST_KEY_D: begin
                if (HRESP)          state_d = ST_ERR;
                else if (HREADY)    state_d = ST_DAT_A;
                else if (timeout_s) state_d = ST_ERR;
                else                state_d = ST_KEY_D;
            end
            ST_DAT_A: state_d = ST_DAT_D;
            ST_DAT_D: begin
                if (HRESP)          state_d = ST_ERR;
                else if (HREADY)    state_d = ST_RD_A;
                else if (timeout_s) state_d = ST_ERR;
                else                state_d = ST_DAT_D;
            end
            ST_RD_A: state_d = ST_RD_D;
            ST_RD_D: begin
                if (HRESP) begin
                    state_d = ST_ERR;
                end else if (HREADY) begin
                    result_d = HRDATA;
                    state_d  = ST_DONE;
                end else if (timeout_s) begin
                    state_d = ST_ERR;
                end else begin
                    state_d = ST_RD_D;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode from the upcoming state so registered outputs match it.
    always_comb begin
        busy_d   = (state_d != ST_IDLE);
        done_d   = 1'b0;
        error_d  = 1'b0;
        haddr_d  = 16'h0000;
        htrans_d = HTRANS_IDLE;
        hwrite_d = 1'b0;
        hwdata_d = 128'h0;
        case (state_d)
            ST_KEY_A: begin
                haddr_d  = KEY_ADDR;
                htrans_d = HTRANS_NONSEQ;
                hwrite_d = 1'b1;
            end
            ST_KEY_D: hwdata_d = key_q;
            ST_DAT_A: begin
                haddr_d  = DATA_ADDR;
                htrans_d = HTRANS_NONSEQ;
                hwrite_d = 1'b1;
            end
            ST_DAT_D: hwdata_d = data_q;
            ST_RD_A: begin
                haddr_d  = DATA_ADDR;
                htrans_d = HTRANS_NONSEQ;
            end
            ST_DONE: done_d  = 1'b1;
            ST_ERR:  error_d = 1'b1;
            default: busy_d  = (state_d != ST_IDLE);
        endcase
    end

    // FSM state, operands and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            key_q    <= 128'h0;
            data_q   <= 128'h0;
            result_q <= 128'h0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            haddr_q  <= 16'h0000;
            htrans_q <= HTRANS_IDLE;
            hwrite_q <= 1'b0;
            hwdata_q <= 128'h0;
        end else begin
            state_q  <= state_d;
            key_q    <= key_d;
            data_q   <= data_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            error_q  <= error_d;
            haddr_q  <= haddr_d;
            htrans_q <= htrans_d;
            hwrite_q <= hwrite_d;
            hwdata_q <= hwdata_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign error  = error_q;
    assign result = result_q;
    assign HADDR  = haddr_q;
    assign HTRANS = htrans_q;
    assign HWRITE = hwrite_q;
    assign HWDATA = hwdata_q;

endmodule

// File: tb/tb_aes_ahb_master.sv
// Directed bench for aes_ahb_master with a result scoreboard.
// Timeout scenario is compiled in only with AHB_MASTER_TIMEOUT_EN.
module tb_aes_ahb_master;
    import aes_ahb_pkg::*;

    logic         clk = 1'b0;
    logic         rst, start, HREADY, HRESP, busy, done, error, HWRITE;
    logic [127:0] key_in, data_in, HRDATA, result, HWDATA;
    logic [15:0]  HADDR;
    logic [1:0]   HTRANS;

    int           checks = 0;
    int           errors = 0;
    logic [127:0] sb_q[$];
    logic [127:0] model_result = 128'h0;
    bit           saw_dat_a;

    localparam logic [127:0] K1 = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [127:0] D1 = {128{1'b1}};

    aes_ahb_master #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .start(start), .key_in(key_in), .data_in(data_in),
        .busy(busy), .done(done), .error(error), .result(result),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HWDATA(HWDATA),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One transaction. Cycle 0 = the cycle in which start is sampled.
    // Negative cycle arguments disable the corresponding stimulus.
    task automatic txn(input string name, input logic [127:0] k, input logic [127:0] d,
                       input logic [127:0] rd, input int wlo, input int whi, input int resp_c,
                       input int start2_c, input int rst_c, input int exp_c,
                       input bit exp_err, input bit chk_bus);
        int           events;
        logic [18:0]  exp_ctl;
        logic [127:0] exp_wd;
        logic [127:0] exp_res;
        events    = 0;
        saw_dat_a = 1'b0;
        if (rst_c < 0) sb_q.push_back(exp_err ? model_result : rd);
        key_in = k; data_in = d; HRDATA = rd;
        start = 1'b1; HRESP = 1'b0; HREADY = 1'b1; rst = 1'b0;
        for (int c = 1; c <= exp_c + 2; c++) begin
            @(negedge clk);
            if (done || error) begin
                events++;
                check($sformatf("%s/end_cycle", name), 128'(c), 128'(exp_c));
                check($sformatf("%s/end_is_error", name), 128'(error), 128'(exp_err));
                if (sb_q.size() > 0) begin
                    exp_res = sb_q.pop_front();
                    check($sformatf("%s/result", name), result, exp_res);
                    model_result = exp_res;
                end else begin
                    check($sformatf("%s/scoreboard_depth", name), 128'(sb_q.size()), 128'(1));
                end
            end
            if (HTRANS == HTRANS_NONSEQ && HWRITE && HADDR == DATA_ADDR) saw_dat_a = 1'b1;
            if (chk_bus && c <= 7) begin
                case (c)
                    1:       begin exp_ctl = {16'h0000, 2'b10, 1'b1}; exp_wd = 128'h0; end
                    2:       begin exp_ctl = {16'h0000, 2'b00, 1'b0}; exp_wd = k;      end
                    3:       begin exp_ctl = {16'h0020, 2'b10, 1'b1}; exp_wd = 128'h0; end
                    4:       begin exp_ctl = {16'h0000, 2'b00, 1'b0}; exp_wd = d;      end
                    5:       begin exp_ctl = {16'h0020, 2'b10, 1'b0}; exp_wd = 128'h0; end
                    default: begin exp_ctl = {16'h0000, 2'b00, 1'b0}; exp_wd = 128'h0; end
                endcase
                check($sformatf("%s/bus_ctl_c%0d", name, c), 128'({HADDR, HTRANS, HWRITE}), 128'(exp_ctl));
                check($sformatf("%s/hwdata_c%0d", name, c), HWDATA, exp_wd);
            end
            if (wlo > 0 && c >= wlo && c <= whi + 1)
                check($sformatf("%s/hwdata_hold_c%0d", name, c), HWDATA, d);
            if (rst_c < 0 && (c == 1 || c == exp_c))
                check($sformatf("%s/busy_c%0d", name, c), 128'(busy), 128'(1));
            if (c == exp_c + 1)
                check($sformatf("%s/idle_after", name), 128'({busy, HTRANS}), 128'(0));
            if (rst_c >= 0 && c == rst_c + 1) begin
                check($sformatf("%s/rst_ctl", name), 128'({busy, done, error, HADDR, HTRANS, HWRITE}), 128'(0));
                check($sformatf("%s/rst_result", name), result, 128'h0);
                check($sformatf("%s/rst_hwdata", name), HWDATA, 128'h0);
            end
            rst    = (c == rst_c);
            start  = (c == start2_c);
            HREADY = !(c >= wlo && c <= whi);
            HRESP  = (c == resp_c);
        end
        check($sformatf("%s/end_pulses", name), 128'(events), 128'((rst_c < 0) ? 1 : 0));
        rst = 1'b0; start = 1'b0; HRESP = 1'b0; HREADY = 1'b1;
        if (rst_c >= 0) model_result = 128'h0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; key_in = 128'h0; data_in = 128'h0;
        HRDATA = 128'h0; HREADY = 1'b1; HRESP = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset/ctl", 128'({busy, done, error, HADDR, HTRANS, HWRITE}), 128'(0));
        check("reset/result", result, 128'h0);
        check("reset/hwdata", HWDATA, 128'h0);
        rst = 1'b0;
        @(negedge clk);

        // name, key, data, rdata, wlo, whi, resp, start2, rst, exp_cycle, exp_err, chk_bus
        txn("zero_wait",   K1, D1, 128'hDEADBEEF, -1, -1, -1, -1, -1, 7, 1'b0, 1'b1);
        txn("dat_wait3",   128'h11, 128'h22, 128'hCAFEF00D_12345678_9ABCDEF0_0F1E2D3C,
                           4, 6, -1, -1, -1, 10, 1'b0, 1'b0);
        txn("key_hresp",   128'h33, 128'h44, 128'h55, -1, -1, 2, -1, -1, 3, 1'b1, 1'b0);
        check("key_hresp/no_dat_a", 128'(saw_dat_a), 128'(0));
        txn("double_start", 128'hA5A5, 128'h5A5A, 128'h0BADC0DE, -1, -1, -1, 4, -1, 7, 1'b0, 1'b1);
        txn("rd_hresp_prio", 128'h66, 128'h77, 128'h88, -1, -1, 6, -1, -1, 7, 1'b1, 1'b0);
        txn("rst_in_rd_d", 128'h99, 128'hAA, 128'hBB, -1, -1, -1, -1, 6, 7, 1'b0, 1'b0);
`ifdef AHB_MASTER_TIMEOUT_EN
        txn("key_timeout", 128'hCC, 128'hDD, 128'hEE, 2, 40, -1, -1, -1, 6, 1'b1, 1'b0);
`endif
        check("scoreboard_empty", 128'(sb_q.size()), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_ahb_master.md
# aes_ahb_master

Bus initiator driving the key/data responder over the simplified AHB-Lite link. On a start request it captures a 128-bit key and a 128-bit plaintext block, writes the key to address 0x0000, writes the data block to 0x0020, then reads 0x0020 back and presents the result. It sits between the test/host control logic and the responder, owning every HADDR/HTRANS/HWRITE/HWDATA transfer and honouring HREADY wait states and HRESP errors.

## Interface
- TIMEOUT_CYCLES, 64: max HREADY-low cycles per data phase (used only with timeout compiled in)
- clk  in  1  system clock
- rst  in  1  reset; one clock; reset is synchronous and active-high
- start  in  1  request pulse; sampled only in IDLE
- key_in  in  128  key operand, captured on accepted start
- data_in  in  128  data operand, captured on accepted start
- busy  out  1  high from cycle after accepted start until return to IDLE
- done  out  1  one-cycle pulse, result valid
- error  out  1  one-cycle pulse, transfer aborted
- result  out  128  last read data; holds until next done or reset
- HADDR  out  16  transfer address
- HTRANS  out  2  2'b10 NONSEQ in address phase, 2'b00 IDLE otherwise
- HWRITE  out  1  1 for write address phases
- HWDATA  out  128  write data, driven in write data phases, 0 otherwise
- HRDATA  in  128  read data from responder
- HREADY  in  1  responder ready; data phase completes when high
- HRESP  in  1  1 = error response

## Operation
- States: IDLE, KEY_A, KEY_D, DAT_A, DAT_D, RD_A, RD_D, DONE, ERR.
- IDLE: start=1 captures key_in/data_in into registers and moves to KEY_A; start=0 stays.
- KEY_A: HADDR=0x0000, HTRANS=NONSEQ, HWRITE=1; next KEY_D unconditionally.
- KEY_D: HWDATA=key register, HTRANS=IDLE; HRESP=1 -> ERR; HREADY=1 -> DAT_A; else hold.
- DAT_A/DAT_D: same as key, HADDR=0x0020, HWDATA=data register.
- RD_A: HADDR=0x0020, HTRANS=NONSEQ, HWRITE=0; next RD_D.
- RD_D: HRESP=1 -> ERR; HREADY=1 -> capture HRDATA into result, go DONE; else hold.
- DONE: done=1, next IDLE. ERR: error=1, result unchanged, next IDLE.
- HRESP takes priority over HREADY when both high in the same data-phase cycle.
- start while not IDLE is ignored; not queued.
- HADDR/HWRITE are 0 outside address phases.

## Timing
- Reset values: busy=0, done=0, error=0, result=0, HADDR=0, HTRANS=2'b00, HWRITE=0, HWDATA=0; state IDLE, operand registers 0.
- Zero-wait-state sequence: start sampled cycle 0; KEY_A cycle 1, KEY_D 2, DAT_A 3, DAT_D 4, RD_A 5, RD_D 6, done=1 and result valid cycle 7; busy=1 cycles 1-7. Each HREADY-low data-phase cycle adds one cycle.
- start accepted again in cycle 8 (first IDLE cycle after DONE).
- All outputs registered from state; no combinational path from HREADY/HRESP to bus outputs.
- rst mid-transfer: next cycle all outputs at reset values, state IDLE, no done/error pulse.

## Configuration
- AHB_MASTER_TIMEOUT_EN defined: per-data-phase counter clears on phase entry, increments each HREADY=0 cycle; reaching TIMEOUT_CYCLES with HREADY=0 -> ERR (error pulse). Counter resets with rst.
- Undefined: no counter; the master waits indefinitely for HREADY; TIMEOUT_CYCLES unused.

## Structure
- Package aes_ahb_pkg: state enum, HTRANS_IDLE/HTRANS_NONSEQ constants, KEY_ADDR=16'h0000, DATA_ADDR=16'h0020.
- Sub-module ahb_wait_timer (counter, clear, expired flag), instantiated only under AHB_MASTER_TIMEOUT_EN.

## Test plan
- Reset then start with key=128'h000102...0F, data=128'hFF..FF, HREADY=1, HRDATA=128'hDEADBEEF -> writes to 0x0000 then 0x0020 with those values, read at 0x0020, done at cycle 7, result=128'hDEADBEEF.
- HREADY low 3 cycles in DAT_D -> HWDATA held stable, done at cycle 10.
- HRESP=1 in KEY_D -> error pulse cycle 3, no DAT_A address phase, result unchanged, busy low afterwards.
- start pulsed at cycles 0 and 4 -> only one transaction, second start ignored.
- rst asserted during RD_D -> next cycle all outputs at reset values, no done.
- With AHB_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=4, HREADY held low in KEY_D -> error pulse after 4 wait cycles, then IDLE.
